reg_writeback_buffer: RTL and testbench
=======================================

# reg_writeback_buffer

Small in-order queue between the execute/load writeback sources and the register file write port. Accepts destination/data pairs through a valid/ready handshake, drains at most one entry per cycle into the register file write port (WriteReg/RegWriteData/RegWEn), and supplies youngest-match bypass data for two source-register lookups so decode never reads a stale register while writes are pending.

## Interface
- DEPTH, 4: number of pending entries; power of two, ≥2.
- XLEN, 32: data width.
- AW, 5: register index width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  writeback request.
- in_ready  out  1  buffer can accept; = !full.
- in_rd  in  AW  destination register.
- in_data  in  XLEN  write data.
- wb_ready  in  1  register file write port available this cycle.
- wb_we  out  1  drives register file RegWEn.
- wb_rd  out  AW  drives WriteReg.
- wb_data  out  XLEN  drives RegWriteData.
- rs1, rs2  in  AW  lookup indices (decode read ports).
- byp1_hit, byp2_hit  out  1  a pending entry targets rsN.
- byp1_data, byp2_data  out  XLEN  data of youngest matching entry; 0 when no hit.
- count  out  clog2(DEPTH)+1  occupancy.

## Operation
- Storage: circular buffer of DEPTH entries {valid, rd, data}, head/tail pointers with one extra wrap bit; full = pointers equal except wrap bit, empty = fully equal.
- Enqueue on in_valid && in_ready at the clock edge. Requests with in_rd == 0 are accepted (handshake completes) but not stored.
- Drain: wb_we = !empty && wb_ready; wb_rd/wb_data = head entry (combinational from storage). Head advances on each edge where wb_we = 1. When empty, wb_rd = 0, wb_data = 0.
- Simultaneous enqueue and drain: both occur; count unchanged. When full, in_ready = 0 even if a drain happens that cycle (no pass-through).
- Order: entries drain strictly in acceptance order; two writes to the same rd both reach the register file, older first.
- Bypass: compare rsN with rd of every valid entry; hit = any match; data = youngest match (closest to tail). rsN == 0 → hit 0, data 0. The entry being drained this cycle still counts as a hit.
- Incoming request on the same cycle is not visible to bypass until it is stored (next cycle).
- Reset (async, any time, including mid-drain): all valid bits 0, pointers 0, count 0; wb_we 0, wb_rd 0, wb_data 0, byp*_hit 0, byp*_data 0, in_ready 1. Entry data fields are not reset.

## Timing
- Enqueue-to-wb_we latency: 1 cycle (entry accepted at edge N is presented from cycle N+1 if it is head and wb_ready = 1).
- Enqueue-to-bypass latency: 1 cycle.
- Throughput: one accept and one drain per cycle sustained.
- in_ready, wb_we, bypass outputs are combinational from registered state and wb_ready/rsN only; no combinational path from in_valid to in_ready.
- wb_ready low holds head stable; outputs unchanged until it rises.
- Pointer wrap at DEPTH-1 → 0 toggles the wrap bit; no other special case.

## Structure
- Shared package cpu_pkg: XLEN, REG_AW, and typedef wb_entry_t {logic valid; logic [REG_AW-1:0] rd; logic [XLEN-1:0] data}.
- One sub-module: wb_bypass_match — combinational youngest-match priority search over the entry array given head pointer and rs index; instantiated twice (rs1, rs2).

## Test plan
- Reset then idle: rst_n low mid-traffic → all outputs 0, in_ready 1, count 0 immediately (asynchronous, before next edge).
- Single write: in rd=5 data=0xDEADBEEF, wb_ready=1 → next cycle wb_we=1, wb_rd=5, wb_data=0xDEADBEEF; byp for rs1=5 hit with same data for that cycle; count returns 0.
- Fill/backpressure: wb_ready=0, push rd=1..4 → count=4, in_ready=0, 5th request not accepted; raise wb_ready → drains 1,2,3,4 on consecutive cycles, in_ready=1 after first drain.
- Youngest match: wb_ready=0, push (rd=7,0x11), (rd=7,0x22), (rd=3,0x33) → rs1=7 gives hit/0x22, rs2=3 gives hit/0x33; drain order 0x11, 0x22, 0x33.
- x0 handling: push rd=0 data=0xFFFF → accepted, count stays 0, wb_we never asserts; rs1=0 → hit 0, data 0.
- Wrap-around and concurrent push/drain: stream 10 writes with wb_ready=1 and in_valid every cycle → all 10 drained in order, one per cycle, count ≤1, pointers wrap without loss.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core types: register-file widths and the writeback queue entry.
package cpu_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_bypass_match.sv
// Youngest-match search over the writeback queue for one decode read port.
module wb_bypass_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [PW-1:0]     head,
  input  logic [REG_AW-1:0] rs,
  output logic              hit,
  output logic [XLEN-1:0]   data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (rs != '0 && entries[idx].valid && entries[idx].rd == rs) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_buffer.sv
// In-order writeback queue feeding the register file write port, with
// youngest-match bypass for the two decode read ports.
module reg_writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int AW    = cpu_pkg::REG_AW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_rd,
  input  logic [XLEN-1:0]            in_data,
  input  logic                       wb_ready,
  output logic                       wb_we,
  output logic [AW-1:0]              wb_rd,
  output logic [XLEN-1:0]            wb_data,
  input  logic [AW-1:0]              rs1,
  input  logic [AW-1:0]              rs2,
  output logic                       byp1_hit,
  output logic                       byp2_hit,
  output logic [XLEN-1:0]            byp1_data,
  output logic [XLEN-1:0]            byp2_data,
  output logic [$clog2(DEPTH):0]     count
);
  import cpu_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      head, tail;
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  wb_entry_t        entries [DEPTH];

  logic full, empty, push, store, pop;

  assign empty    = (head == tail);
  assign full     = (head[PW] != tail[PW]) && (head[PW-1:0] == tail[PW-1:0]);
  assign in_ready = !full;
  assign count    = tail - head;

  assign push  = in_valid && in_ready;
  // x0 writes complete the handshake but never occupy a slot.
  assign store = push && (in_rd != '0);
  assign wb_we = !empty && wb_ready;
  assign pop   = wb_we;

  assign wb_rd   = empty ? '0 : rd_q[head[PW-1:0]];
  assign wb_data = empty ? '0 : data_q[head[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      valid_q <= '0;
    end else begin
      if (store) begin
        tail                   <= tail + 1'b1;
        valid_q[tail[PW-1:0]]  <= 1'b1;
      end
      if (pop) begin
        head                   <= head + 1'b1;
        valid_q[head[PW-1:0]]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      rd_q[tail[PW-1:0]]   <= in_rd;
      data_q[tail[PW-1:0]] <= in_data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i].valid = valid_q[i];
      entries[i].rd    = rd_q[i];
      entries[i].data  = data_q[i];
    end
  end

  wb_bypass_match #(.DEPTH(DEPTH)) u_byp1 (
    .entries (entries),
    .head    (head[PW-1:0]),
    .rs      (rs1),
    .hit     (byp1_hit),
    .data    (byp1_data)
  );

  wb_bypass_match #(.DEPTH(DEPTH)) u_byp2 (
    .entries (entries),
    .head    (head[PW-1:0]),
    .rs      (rs2),
    .hit     (byp2_hit),
    .data    (byp2_data)
  );

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Directed checks for reg_writeback_buffer: reset, single write, fill,
// youngest-match bypass, x0 handling, and wrap-around streaming.
module tb_reg_writeback_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        wb_ready, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rs1, rs2;
  logic        byp1_hit, byp2_hit;
  logic [31:0] byp1_data, byp2_data;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_writeback_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1(rs1), .rs2(rs2),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit),
    .byp1_data(byp1_data), .byp2_data(byp2_data),
    .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_rd = 0; in_data = 0;
    wb_ready = 0; rs1 = 0; rs2 = 0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_wb_we", 32'(wb_we), 0);

    // Single write, bypass visible only after it is stored
    in_valid = 1; in_rd = 5; in_data = 32'hDEADBEEF; wb_ready = 1; rs1 = 5;
    #1;
    chk("same_cycle_no_bypass", 32'(byp1_hit), 0);
    step();
    in_valid = 0;
    #1;
    chk("single_wb_we", 32'(wb_we), 1);
    chk("single_wb_rd", 32'(wb_rd), 5);
    chk("single_wb_data", wb_data, 32'hDEADBEEF);
    chk("single_byp_hit", 32'(byp1_hit), 1);
    chk("single_byp_data", byp1_data, 32'hDEADBEEF);
    step();
    chk("single_count_after", 32'(count), 0);
    chk("single_we_after", 32'(wb_we), 0);
    chk("single_empty_wb_data", wb_data, 0);

    // Fill with backpressure
    wb_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_rd = 5'(i); in_data = 32'h100 + 32'(i);
      step();
    end
    in_rd = 9; in_data = 32'h999;
    #1;
    chk("fill_count", 32'(count), 4);
    chk("fill_in_ready", 32'(in_ready), 0);
    step();
    chk("fill_fifth_rejected", 32'(count), 4);
    in_valid = 0;
    wb_ready = 1;
    #1;
    chk("fill_full_no_passthru", 32'(in_ready), 0);
    chk("drain1_rd", 32'(wb_rd), 1);
    chk("drain1_data", wb_data, 32'h101);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("drain_rd", 32'(wb_rd), 32'(i));
      chk("drain_data", wb_data, 32'h100 + 32'(i));
      chk("drain_in_ready", 32'(in_ready), 1);
      chk("drain_count", 32'(count), 32'(5 - i));
    end
    step();
    chk("drain_done_count", 32'(count), 0);
    chk("drain_done_we", 32'(wb_we), 0);

    // Youngest match
    wb_ready = 0;
    in_valid = 1; in_rd = 7; in_data = 32'h11; step();
    in_rd = 7; in_data = 32'h22; step();
    in_rd = 3; in_data = 32'h33; step();
    in_valid = 0; rs1 = 7; rs2 = 3;
    #1;
    chk("young_count", 32'(count), 3);
    chk("young_byp1_hit", 32'(byp1_hit), 1);
    chk("young_byp1_data", byp1_data, 32'h22);
    chk("young_byp2_hit", 32'(byp2_hit), 1);
    chk("young_byp2_data", byp2_data, 32'h33);
    rs2 = 4;
    #1;
    chk("young_byp2_miss", 32'(byp2_hit), 0);
    chk("young_byp2_miss_data", byp2_data, 0);
    step();
    chk("young_hold_data", wb_data, 32'h11);
    wb_ready = 1;
    #1;
    chk("young_drain0", wb_data, 32'h11);
    step();
    chk("young_drain1", wb_data, 32'h22);
    chk("young_drain_hit", 32'(byp1_hit), 1);
    step();
    chk("young_drain2", wb_data, 32'h33);
    chk("young_no_more_7", 32'(byp1_hit), 0);
    step();
    chk("young_empty", 32'(count), 0);

    // x0 writes are accepted but dropped
    in_valid = 1; in_rd = 0; in_data = 32'hFFFF;
    #1;
    chk("x0_ready", 32'(in_ready), 1);
    step();
    in_valid = 0; rs1 = 0;
    #1;
    chk("x0_count", 32'(count), 0);
    chk("x0_wb_we", 32'(wb_we), 0);
    chk("x0_byp_hit", 32'(byp1_hit), 0);
    chk("x0_byp_data", byp1_data, 0);

    // Streaming with wrap-around
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_rd = 5'((i % 7) + 1); in_data = 32'hA000 + 32'(i);
      step();
      chk("stream_we", 32'(wb_we), 1);
      chk("stream_data", wb_data, 32'hA000 + 32'(i));
      chk("stream_count", 32'(count), 1);
    end
    in_valid = 0;
    step();
    chk("stream_end_count", 32'(count), 0);

    // Asynchronous reset mid-traffic
    wb_ready = 0;
    in_valid = 1; in_rd = 12; in_data = 32'h55; step();
    in_rd = 13; in_data = 32'h66; step();
    in_valid = 0; wb_ready = 1; rs1 = 12; rs2 = 13;
    #1;
    chk("pre_rst_count", 32'(count), 2);
    #1;
    rst_n = 0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_wb_we", 32'(wb_we), 0);
    chk("arst_wb_rd", 32'(wb_rd), 0);
    chk("arst_wb_data", wb_data, 0);
    chk("arst_byp1_hit", 32'(byp1_hit), 0);
    chk("arst_byp2_data", byp2_data, 0);
    step();
    rst_n = 1;
    step();
    chk("post_rst_count", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
